// File: rtl/router_ovch_credit_tracker.sv
// Output virtual-channel state and downstream credit tracking for one router
// output port. Each output VC goes IDLE -> ACTIVE -> DRAIN -> IDLE. New packets
// are given free VCs by a round-robin allocator. Credit counters are
// decremented by sent flits and incremented by credits returned from
// downstream. A VC goes back to IDLE only after every downstream buffer slot
// has been returned, so a reused VC always starts with a full credit count.
module router_ovch_credit_tracker #(
  parameter int unsigned NUM_VC    = 2,
  parameter int unsigned BUF_DEPTH = 4,
  localparam int unsigned CW       = $clog2(BUF_DEPTH + 1),
  localparam int unsigned VW       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [NUM_VC-1:0]    alloc_vc,
  input  logic                 flit_valid,
  input  logic [VW-1:0]        flit_vc,
  input  logic                 flit_tail,
  input  logic                 credit_valid,
  input  logic [VW-1:0]        credit_vc,
  output logic [NUM_VC-1:0]    ovch_busy,
  output logic [NUM_VC-1:0]    ovch_credit_ok,
  output logic [NUM_VC*CW-1:0] credit_cnt,
  output logic                 err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } vc_state_e;

  logic [VW-1:0]     rr_q;
  logic [VW-1:0]     rr_d;
  logic [VW-1:0]     win;
  logic [VW-1:0]     cand;
  logic              gnt;
  logic [NUM_VC-1:0] gnt_vc;
  logic [NUM_VC-1:0] idle_vec;
  logic [NUM_VC-1:0] bad_vec;
  logic [NUM_VC-1:0] over_vec;
  logic              err_q;

  // Round-robin search for the first IDLE VC at or after the pointer.
  // Grants are masked while reset is held so nothing is reported to the
  // allocator during reset.
  always_comb begin
    gnt    = 1'b0;
    gnt_vc = '0;
    win    = '0;
    cand   = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      cand = VW'((32'(rr_q) + i) % NUM_VC);
      if (alloc_req && reset && !gnt && idle_vec[cand]) begin
        gnt         = 1'b1;
        gnt_vc[cand] = 1'b1;
        win         = cand;
      end
    end
  end

  assign alloc_gnt = gnt;
  assign alloc_vc  = gnt_vc;

  // Next pointer is one past the winner, wrapping at NUM_VC (not a power of 2 in general).
  always_comb begin
    rr_d = rr_q;
    if (gnt) begin
      rr_d = (win == VW'(NUM_VC - 1)) ? '0 : win + VW'(1);
    end
  end

  // Round-robin pointer and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      err_q <= err_q | (|bad_vec) | (|over_vec);
    end
  end

  assign err = err_q;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_state_e     st_q;
    vc_state_e     st_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          busy_q;
    logic          ok_q;
    logic          flit_hit;
    logic          cred_hit;
    logic          dec;
    logic [CW:0]   sum;

    assign flit_hit = flit_valid && (flit_vc == VW'(v));
    assign cred_hit = credit_valid && (credit_vc == VW'(v));

    // A flit is a protocol error unless the VC is ACTIVE with a credit available.
    assign bad_vec[v] = flit_hit && ((st_q != ST_ACTIVE) || (cnt_q == '0));

    // An empty counter never decrements. This blocks wrap on an illegal send.
    assign dec  = flit_hit && (cnt_q != '0);
    assign sum  = {1'b0, cnt_q} - (CW+1)'(dec) + (CW+1)'(cred_hit);

    // A credit beyond the buffer depth is flagged and saturated.
    assign over_vec[v] = sum > (CW+1)'(BUF_DEPTH);
    assign cnt_d       = over_vec[v] ? CW'(BUF_DEPTH) : sum[CW-1:0];

    assign idle_vec[v] = (st_q == ST_IDLE);

    // Per-VC state transitions. DRAIN releases on the post-edge count, so a
    // tail and a credit in the same cycle are counted before the drain check.
    always_comb begin
      st_d = st_q;
      case (st_q)
        ST_IDLE: begin
          if (gnt_vc[v]) st_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (flit_hit && flit_tail) st_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (cnt_d == CW'(BUF_DEPTH)) st_d = ST_IDLE;
        end
        default: st_d = ST_IDLE;
      endcase
    end

    // State, credit count and the registered flags derived from post-edge values.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        st_q   <= ST_IDLE;
        cnt_q  <= CW'(BUF_DEPTH);
        busy_q <= 1'b0;
        ok_q   <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        busy_q <= (st_d != ST_IDLE);
        ok_q   <= (st_d == ST_ACTIVE) && (cnt_d != '0);
      end
    end

    assign ovch_busy[v]            = busy_q;
    assign ovch_credit_ok[v]       = ok_q;
    assign credit_cnt[v*CW +: CW]  = cnt_q;
  end

endmodule

// File: tb/tb_router_ovch_credit_tracker.sv
// Self-checking bench for router_ovch_credit_tracker with NUM_VC=2, BUF_DEPTH=4.
// The reference model tracks, for each VC, whether the VC is owned by a packet,
// whether that packet's tail has gone out, and how many credits are held.
module tb_router_ovch_credit_tracker;

  localparam int NV  = 2;
  localparam int BD  = 4;
  localparam int CWT = 3;
  localparam int VWT = 1;

  logic              clk;
  logic              reset;
  logic              alloc_req;
  logic              alloc_gnt;
  logic [NV-1:0]     alloc_vc;
  logic              flit_valid;
  logic [VWT-1:0]    flit_vc;
  logic              flit_tail;
  logic              credit_valid;
  logic [VWT-1:0]    credit_vc;
  logic [NV-1:0]     ovch_busy;
  logic [NV-1:0]     ovch_credit_ok;
  logic [NV*CWT-1:0] credit_cnt;
  logic              err;

  int nchk;
  int nfail;

  // Reference model state.
  int cnt_m [NV];
  bit own_m [NV];
  bit tail_m[NV];
  int rr_m;
  bit err_m;

  router_ovch_credit_tracker #(.NUM_VC(NV), .BUF_DEPTH(BD)) dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_req      (alloc_req),
    .alloc_gnt      (alloc_gnt),
    .alloc_vc       (alloc_vc),
    .flit_valid     (flit_valid),
    .flit_vc        (flit_vc),
    .flit_tail      (flit_tail),
    .credit_valid   (credit_valid),
    .credit_vc      (credit_vc),
    .ovch_busy      (ovch_busy),
    .ovch_credit_ok (ovch_credit_ok),
    .credit_cnt     (credit_cnt),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      cnt_m[v]  = BD;
      own_m[v]  = 1'b0;
      tail_m[v] = 1'b0;
    end
    rr_m  = 0;
    err_m = 1'b0;
  endfunction

  function automatic void model_grant(output bit g, output int w);
    g = 1'b0;
    w = 0;
    if (alloc_req) begin
      for (int k = 0; k < NV; k++) begin
        int c;
        c = (rr_m + k) % NV;
        if (!g && !own_m[c]) begin
          g = 1'b1;
          w = c;
        end
      end
    end
  endfunction

  function automatic logic [NV-1:0] exp_vc();
    bit g;
    int w;
    logic [NV-1:0] r;
    model_grant(g, w);
    r = '0;
    if (g) r[w] = 1'b1;
    return r;
  endfunction

  function automatic logic exp_gnt();
    bit g;
    int w;
    model_grant(g, w);
    return g;
  endfunction

  function automatic logic [NV-1:0] exp_busy();
    logic [NV-1:0] r;
    for (int v = 0; v < NV; v++) r[v] = own_m[v];
    return r;
  endfunction

  function automatic logic [NV-1:0] exp_ok();
    logic [NV-1:0] r;
    for (int v = 0; v < NV; v++) r[v] = own_m[v] && !tail_m[v] && (cnt_m[v] != 0);
    return r;
  endfunction

  function automatic logic [NV*CWT-1:0] exp_cnt();
    logic [NV*CWT-1:0] r;
    for (int v = 0; v < NV; v++) r[v*CWT +: CWT] = CWT'(cnt_m[v]);
    return r;
  endfunction

  // Apply one clock edge of the current inputs to the model.
  function automatic void model_edge();
    bit g;
    int w;
    model_grant(g, w);
    for (int v = 0; v < NV; v++) begin
      bit f;
      bit c;
      int n;
      f = flit_valid && (int'(flit_vc) == v);
      c = credit_valid && (int'(credit_vc) == v);
      if (f && (!(own_m[v] && !tail_m[v]) || cnt_m[v] == 0)) err_m = 1'b1;
      n = cnt_m[v] - ((f && cnt_m[v] > 0) ? 1 : 0) + (c ? 1 : 0);
      if (n > BD) begin
        err_m = 1'b1;
        n = BD;
      end
      if (own_m[v] && tail_m[v]) begin
        if (n == BD) begin
          own_m[v]  = 1'b0;
          tail_m[v] = 1'b0;
        end
      end else if (own_m[v]) begin
        if (f && flit_tail) tail_m[v] = 1'b1;
      end else if (g && w == v) begin
        own_m[v] = 1'b1;
      end
      cnt_m[v] = n;
    end
    if (g) rr_m = (w + 1) % NV;
  endfunction

  task automatic drive(input bit a, input bit fv, input int fc, input bit ft,
                       input bit cv, input int cc);
    alloc_req    = a;
    flit_valid   = fv;
    flit_vc      = VWT'(fc);
    flit_tail    = ft;
    credit_valid = cv;
    credit_vc    = VWT'(cc);
    #1;
  endtask

  // Clock the model and the DUT, then return at the next falling edge.
  task automatic advance();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    nchk++;
    if (ovch_busy !== 2'b00 || ovch_credit_ok !== 2'b00) begin
      nfail++;
      $display("FAIL reset_flags busy=%b ok=%b required 00/00", ovch_busy, ovch_credit_ok);
    end
    nchk++;
    if (credit_cnt !== {3'd4, 3'd4} || err !== 1'b0) begin
      nfail++;
      $display("FAIL reset_cnt cnt=%h err=%b required %h/0", credit_cnt, err, {3'd4, 3'd4});
    end
    nchk++;
    if (alloc_gnt !== 1'b0 || alloc_vc !== 2'b00) begin
      nfail++;
      $display("FAIL reset_idle_gnt gnt=%b vc=%b required 0/00", alloc_gnt, alloc_vc);
    end
  endtask

  task automatic test_alloc();
    drive(1, 0, 0, 0, 0, 0);
    nchk++;
    if (alloc_gnt !== 1'b1 || alloc_vc !== 2'b01) begin
      nfail++;
      $display("FAIL alloc_first gnt=%b vc=%b required 1/01", alloc_gnt, alloc_vc);
    end
    advance();
    nchk++;
    if (ovch_busy !== 2'b01 || ovch_credit_ok !== 2'b01) begin
      nfail++;
      $display("FAIL alloc_first_flags busy=%b ok=%b required 01/01", ovch_busy, ovch_credit_ok);
    end
    drive(1, 0, 0, 0, 0, 0);
    nchk++;
    if (alloc_gnt !== 1'b1 || alloc_vc !== 2'b10) begin
      nfail++;
      $display("FAIL alloc_second gnt=%b vc=%b required 1/10", alloc_gnt, alloc_vc);
    end
    advance();
    drive(1, 0, 0, 0, 0, 0);
    nchk++;
    if (alloc_gnt !== 1'b0 || alloc_vc !== 2'b00 || ovch_busy !== 2'b11) begin
      nfail++;
      $display("FAIL alloc_full gnt=%b vc=%b busy=%b required 0/00/11", alloc_gnt, alloc_vc, ovch_busy);
    end
    advance();
    nchk++;
    if (err !== 1'b0 || rr_m != 0) begin
      nfail++;
      $display("FAIL alloc_full_noerr err=%b model_rr=%0d required 0/0", err, rr_m);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, (i == 3), 0, 0);
      advance();
      nchk++;
      if (credit_cnt[2:0] !== 3'(3 - i) || credit_cnt !== exp_cnt()) begin
        nfail++;
        $display("FAIL drain_send%0d cnt=%h required vc0=%0d all=%h", i, credit_cnt, 3 - i, exp_cnt());
      end
    end
    nchk++;
    if (ovch_busy[0] !== 1'b1 || ovch_credit_ok[0] !== 1'b0 || err !== 1'b0) begin
      nfail++;
      $display("FAIL drain_state busy0=%b ok0=%b err=%b required 1/0/0", ovch_busy[0], ovch_credit_ok[0], err);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 0);
      advance();
      nchk++;
      if (ovch_busy[0] !== (i != 3) || credit_cnt[2:0] !== 3'(i + 1)) begin
        nfail++;
        $display("FAIL drain_credit%0d busy0=%b cnt0=%0d required %0d/%0d", i, ovch_busy[0], credit_cnt[2:0], (i != 3), i + 1);
      end
    end
    drive(1, 0, 0, 0, 0, 0);
    nchk++;
    if (alloc_gnt !== 1'b1 || alloc_vc !== 2'b01) begin
      nfail++;
      $display("FAIL drain_regrant gnt=%b vc=%b required 1/01", alloc_gnt, alloc_vc);
    end
    advance();
    nchk++;
    if (ovch_credit_ok !== 2'b11 || credit_cnt !== {3'd4, 3'd4}) begin
      nfail++;
      $display("FAIL drain_reuse ok=%b cnt=%h required 11/%h", ovch_credit_ok, credit_cnt, {3'd4, 3'd4});
    end
  endtask

  task automatic test_same_cycle();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 1, 0, 0, 0);
      advance();
    end
    drive(0, 1, 1, 0, 1, 1);
    advance();
    nchk++;
    if (credit_cnt[5:3] !== 3'd2 || err !== 1'b0 || ovch_credit_ok[1] !== 1'b1) begin
      nfail++;
      $display("FAIL same_cycle cnt1=%0d err=%b ok1=%b required 2/0/1", credit_cnt[5:3], err, ovch_credit_ok[1]);
    end
  endtask

  task automatic test_errors();
    do_reset();
    drive(0, 0, 0, 0, 1, 1);
    advance();
    nchk++;
    if (err !== 1'b1 || credit_cnt[5:3] !== 3'd4) begin
      nfail++;
      $display("FAIL err_overcredit err=%b cnt1=%0d required 1/4", err, credit_cnt[5:3]);
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) advance();
    nchk++;
    if (err !== 1'b1) begin
      nfail++;
      $display("FAIL err_sticky err=%b required 1", err);
    end
    do_reset();
    drive(0, 1, 0, 1, 0, 0);
    advance();
    nchk++;
    if (err !== 1'b1 || ovch_busy !== 2'b00 || credit_cnt !== exp_cnt()) begin
      nfail++;
      $display("FAIL err_idle_flit err=%b busy=%b cnt=%h required 1/00/%h", err, ovch_busy, credit_cnt, exp_cnt());
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      advance();
    end
    nchk++;
    if (credit_cnt[2:0] !== 3'd0 || err !== 1'b1) begin
      nfail++;
      $display("FAIL err_nowrap cnt0=%0d err=%b required 0/1", credit_cnt[2:0], err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      advance();
    end
    nchk++;
    if (credit_cnt[2:0] !== 3'd1 || ovch_busy !== 2'b01) begin
      nfail++;
      $display("FAIL async_pre cnt0=%0d busy=%b required 1/01", credit_cnt[2:0], ovch_busy);
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    reset = 1'b0;
    #1;
    nchk++;
    if (ovch_busy !== 2'b00 || ovch_credit_ok !== 2'b00 || credit_cnt !== {3'd4, 3'd4} || err !== 1'b0) begin
      nfail++;
      $display("FAIL async_reset busy=%b ok=%b cnt=%h err=%b required 00/00/%h/0", ovch_busy, ovch_credit_ok, credit_cnt, err, {3'd4, 3'd4});
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    nchk++;
    if (alloc_gnt !== 1'b1 || alloc_vc !== 2'b01) begin
      nfail++;
      $display("FAIL async_regrant gnt=%b vc=%b required 1/01", alloc_gnt, alloc_vc);
    end
    advance();
    nchk++;
    if (ovch_busy !== 2'b01 || credit_cnt[2:0] !== 3'd4) begin
      nfail++;
      $display("FAIL async_after busy=%b cnt0=%0d required 01/4", ovch_busy, credit_cnt[2:0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int legal[$];
      int pend[$];
      bit a, fv, ft, cv;
      int fc, cc;
      legal.delete();
      pend.delete();
      for (int v = 0; v < NV; v++) begin
        if (own_m[v] && !tail_m[v] && cnt_m[v] > 0) legal.push_back(v);
        if (cnt_m[v] < BD) pend.push_back(v);
      end
      a  = ($urandom_range(0, 3) == 0);
      fv = 1'b0; fc = 0; ft = 1'b0;
      if (legal.size() > 0 && $urandom_range(0, 1) == 1) begin
        fv = 1'b1;
        fc = legal[$urandom_range(0, legal.size() - 1)];
        ft = ($urandom_range(0, 3) == 0);
      end else if ($urandom_range(0, 60) == 0) begin
        fv = 1'b1;
        fc = $urandom_range(0, NV - 1);
        ft = $urandom_range(0, 1);
      end
      cv = 1'b0; cc = 0;
      if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
        cv = 1'b1;
        cc = pend[$urandom_range(0, pend.size() - 1)];
      end else if ($urandom_range(0, 80) == 0) begin
        cv = 1'b1;
        cc = $urandom_range(0, NV - 1);
      end
      drive(a, fv, fc, ft, cv, cc);
      nchk++;
      if (alloc_gnt !== exp_gnt() || alloc_vc !== exp_vc()) begin
        nfail++;
        $display("FAIL rand_grant cyc=%0d gnt=%b vc=%b required %b/%b", cyc, alloc_gnt, alloc_vc, exp_gnt(), exp_vc());
      end
      advance();
      nchk++;
      if (ovch_busy !== exp_busy() || ovch_credit_ok !== exp_ok() ||
          credit_cnt !== exp_cnt() || err !== err_m) begin
        nfail++;
        $display("FAIL rand_state cyc=%0d busy=%b ok=%b cnt=%h err=%b required %b/%b/%h/%b",
                 cyc, ovch_busy, ovch_credit_ok, credit_cnt, err, exp_busy(), exp_ok(), exp_cnt(), err_m);
      end
    end
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_alloc();
    test_drain();
    test_same_cycle();
    test_errors();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
